// File: rtl/cp0_exc_pkg.sv
// rtl/cp0_exc_pkg.sv - CP0 register addresses, exception codes and field positions
package cp0_exc_pkg;

    localparam logic [7:0] CP0_BADVADDR = 8'h40;
    localparam logic [7:0] CP0_COUNT    = 8'h48;
    localparam logic [7:0] CP0_COMPARE  = 8'h58;
    localparam logic [7:0] CP0_STATUS   = 8'h60;
    localparam logic [7:0] CP0_CAUSE    = 8'h68;
    localparam logic [7:0] CP0_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_BEV = 22;
    localparam int CA_BD  = 31;
    localparam int CA_TI  = 30;

endpackage

// File: rtl/cp0_exc_timer.sv
// rtl/cp0_exc_timer.sv - CP0 Count/Compare timer with TI flag
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] CountOut,
    output logic [31:0] CompareOut,
    output logic        TI
);

    logic tick;

    always_ff @(posedge clk) begin
        if (!rst) begin
            CountOut   <= 32'd0;
            CompareOut <= 32'd0;
            tick       <= 1'b0;
            TI         <= 1'b0;
        end else begin
            if (count_we) begin
                CountOut <= wdata;
                tick     <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick)
                    CountOut <= CountOut + 32'd1;
            end
            // A Compare write takes precedence over a match on the same edge
            if (compare_we) begin
                CompareOut <= wdata;
                TI         <= 1'b0;
            end else if (CountOut == CompareOut) begin
                TI <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc.sv
// rtl/cp0_exc.sv - CP0 exception commit unit: arbitration, flush/redirect, mfc0/mtc0
module cp0_exc
    import cp0_exc_pkg::*;
#(
    parameter logic [31:0] EXC_VEC    = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_Exception,
    input  logic [4:0]  MEM_ExcCode,
    input  logic        MEM_isBD,
    input  logic [31:0] badvaddr,
    input  logic        MEM_eret_flush,
    input  logic        MEM_CP0WrEn,
    input  logic        MEM_CP0Rd,
    input  logic [7:0]  MEM_CP0Addr,
    input  logic [31:0] MEM_GPR_RT,
    input  logic [5:0]  hw_int,
    output logic [31:0] CP0Out,
    output logic        Exc_Flush,
    output logic        Exc_Redirect,
    output logic [31:0] Exc_NPC
);

    logic [31:0] badvaddr_r, epc_r, count, compare;
    logic [7:0]  im;
    logic        exl, ie, bd, ti;
    logic [4:0]  exccode;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw;
    logic [31:0] status_rd, cause_rd;
    logic        int_req, int_take, exc_take, eret_take, wr_en;
    logic [4:0]  exc_code;

    assign int_req   = ie & ~exl & |({ip_hw, ip_sw} & im);
    assign int_take  = int_req & (MEM_PC != 32'd0);
    assign exc_take  = int_take | MEM_Exception;
    assign eret_take = MEM_eret_flush & ~exc_take;
    assign wr_en     = MEM_CP0WrEn & ~exc_take & ~MEM_eret_flush;
    assign exc_code  = int_take ? EXC_INT : MEM_ExcCode;

    always_comb begin
        status_rd         = 32'd0;
        status_rd[ST_BEV] = 1'b1;
        status_rd[15:8]   = im;
        status_rd[ST_EXL] = exl;
        status_rd[ST_IE]  = ie;
        cause_rd          = 32'd0;
        cause_rd[CA_BD]   = bd;
        cause_rd[CA_TI]   = ti;
        cause_rd[15:8]    = {ip_hw, ip_sw};
        cause_rd[6:2]     = exccode;
    end

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_en && (MEM_CP0Addr == CP0_COUNT)),
        .compare_we (wr_en && (MEM_CP0Addr == CP0_COMPARE)),
        .wdata      (MEM_GPR_RT),
        .CountOut   (count),
        .CompareOut (compare),
        .TI         (ti)
    );

    always_comb begin
        CP0Out       = 32'd0;
        Exc_Flush    = 1'b0;
        Exc_Redirect = 1'b0;
        Exc_NPC      = 32'd0;
        if (rst) begin
            if (MEM_CP0Rd) begin
                case (MEM_CP0Addr)
                    CP0_BADVADDR: CP0Out = badvaddr_r;
                    CP0_COUNT:    CP0Out = count;
                    CP0_COMPARE:  CP0Out = compare;
                    CP0_STATUS:   CP0Out = status_rd;
                    CP0_CAUSE:    CP0Out = cause_rd;
                    CP0_EPC:      CP0Out = epc_r;
                    default:      CP0Out = 32'd0;
                endcase
            end
            if (exc_take) begin
                Exc_Flush    = 1'b1;
                Exc_Redirect = 1'b1;
                Exc_NPC      = EXC_VEC;
            end else if (eret_take) begin
                Exc_Flush    = 1'b1;
                Exc_Redirect = 1'b1;
                Exc_NPC      = epc_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            badvaddr_r <= 32'd0;
            epc_r      <= 32'd0;
            im         <= STATUS_RST[15:8];
            exl        <= STATUS_RST[ST_EXL];
            ie         <= STATUS_RST[ST_IE];
            bd         <= 1'b0;
            exccode    <= 5'd0;
            ip_sw      <= 2'd0;
            ip_hw      <= 6'd0;
        end else begin
            ip_hw <= {ti | hw_int[5], hw_int[4:0]};
            if (exc_take) begin
                // A nested exception keeps the original return point
                if (!exl) begin
                    epc_r <= MEM_isBD ? MEM_PC - 32'd4 : MEM_PC;
                    bd    <= MEM_isBD;
                end
                exl     <= 1'b1;
                exccode <= exc_code;
                if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                    badvaddr_r <= badvaddr;
            end else if (eret_take) begin
                exl <= 1'b0;
            end else if (wr_en) begin
                case (MEM_CP0Addr)
                    CP0_STATUS: begin
                        im  <= MEM_GPR_RT[15:8];
                        exl <= MEM_GPR_RT[ST_EXL];
                        ie  <= MEM_GPR_RT[ST_IE];
                    end
                    CP0_CAUSE: ip_sw <= MEM_GPR_RT[9:8];
                    CP0_EPC:   epc_r <= MEM_GPR_RT;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc.sv
// tb/tb_cp0_exc.sv - scoreboard bench for cp0_exc with a behavioural CP0 model
module tb_cp0_exc;
    import cp0_exc_pkg::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] MEM_PC, badvaddr, MEM_GPR_RT;
    logic        MEM_Exception, MEM_isBD, MEM_eret_flush, MEM_CP0WrEn, MEM_CP0Rd;
    logic [4:0]  MEM_ExcCode;
    logic [7:0]  MEM_CP0Addr;
    logic [5:0]  hw_int;
    logic [31:0] CP0Out, Exc_NPC;
    logic        Exc_Flush, Exc_Redirect;

    always #5 clk = ~clk;

    cp0_exc dut (
        .clk(clk), .rst(rst), .MEM_PC(MEM_PC), .MEM_Exception(MEM_Exception),
        .MEM_ExcCode(MEM_ExcCode), .MEM_isBD(MEM_isBD), .badvaddr(badvaddr),
        .MEM_eret_flush(MEM_eret_flush), .MEM_CP0WrEn(MEM_CP0WrEn), .MEM_CP0Rd(MEM_CP0Rd),
        .MEM_CP0Addr(MEM_CP0Addr), .MEM_GPR_RT(MEM_GPR_RT), .hw_int(hw_int),
        .CP0Out(CP0Out), .Exc_Flush(Exc_Flush), .Exc_Redirect(Exc_Redirect), .Exc_NPC(Exc_NPC)
    );

    typedef struct packed {
        logic        rst;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] bva;
        logic        eret;
        logic        we;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [5:0]  hw;
    } txn_t;

    typedef struct packed {
        logic        flush;
        logic        redir;
        logic [31:0] npc;
        logic [31:0] out;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Architectural state of the reference model
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [31:0] m_epc, m_bva, m_cmp, m_base, m_k;

    task automatic model_reset();
        m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
        m_code = 5'd0; m_ipsw = 2'd0; m_iphw = 6'd0;
        m_epc = 32'd0; m_bva = 32'd0; m_cmp = 32'd0; m_base = 32'd0; m_k = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [31:0] cnt);
        case (a)
            CP0_BADVADDR: return m_bva;
            CP0_COUNT:    return cnt;
            CP0_COMPARE:  return m_cmp;
            CP0_STATUS:   return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
            CP0_CAUSE:    return {m_bd, m_ti, 14'd0, m_iphw, m_ipsw, 1'b0, m_code, 2'b00};
            CP0_EPC:      return m_epc;
            default:      return 32'd0;
        endcase
    endfunction

    function automatic txn_t idle();
        txn_t t = '0;
        t.rst = 1'b1;
        return t;
    endfunction

    function automatic txn_t rd(input logic [7:0] a);
        txn_t t = idle();
        t.rd = 1'b1; t.addr = a;
        return t;
    endfunction

    function automatic txn_t wr(input logic [7:0] a, input logic [31:0] d);
        txn_t t = idle();
        t.we = 1'b1; t.addr = a; t.wd = d;
        return t;
    endfunction

    function automatic txn_t exc(input logic [31:0] pc, input logic [4:0] code,
                                 input logic bd, input logic [31:0] bva);
        txn_t t = idle();
        t.pc = pc; t.exc = 1'b1; t.code = code; t.bd = bd; t.bva = bva;
        return t;
    endfunction

    // Drives one MEM-stage cycle, pushes the predicted response, then advances the model
    task automatic step(input txn_t t, input bit fv = 1'b0, input logic [31:0] fval = 32'd0);
        rsp_t r;
        logic [31:0] cnt_now;
        logic [5:0]  new_iphw;
        logic        take_int, ex, er, we;
        logic [4:0]  code;
        @(posedge clk); #1;
        rst = t.rst; MEM_PC = t.pc; MEM_Exception = t.exc; MEM_ExcCode = t.code;
        MEM_isBD = t.bd; badvaddr = t.bva; MEM_eret_flush = t.eret; MEM_CP0WrEn = t.we;
        MEM_CP0Rd = t.rd; MEM_CP0Addr = t.addr; MEM_GPR_RT = t.wd; hw_int = t.hw;
        r = '0;
        if (!t.rst) begin
            model_reset();
        end else begin
            cnt_now  = m_base + (m_k >> 1);
            take_int = m_ie && !m_exl && (({m_iphw, m_ipsw} & m_im) != 8'd0) && (t.pc != 32'd0);
            ex   = take_int || t.exc;
            er   = t.eret && !ex;
            we   = t.we && !ex && !er;
            code = take_int ? EXC_INT : t.code;
            if (t.rd) r.out = model_read(t.addr, cnt_now);
            if (ex) begin
                r.flush = 1'b1; r.redir = 1'b1; r.npc = VEC;
            end else if (er) begin
                r.flush = 1'b1; r.redir = 1'b1; r.npc = m_epc;
            end
            if (fv) r.out = fval;
            new_iphw = {m_ti | t.hw[5], t.hw[4:0]};
            if (we && t.addr == CP0_COMPARE) begin
                m_ti = 1'b0; m_cmp = t.wd;
            end else if (cnt_now == m_cmp) begin
                m_ti = 1'b1;
            end
            if (we && t.addr == CP0_COUNT) begin
                m_base = t.wd; m_k = 32'd0;
            end else begin
                m_k = m_k + 32'd1;
            end
            if (ex) begin
                if (!m_exl) begin
                    m_epc = t.bd ? t.pc - 32'd4 : t.pc;
                    m_bd  = t.bd;
                end
                m_exl  = 1'b1;
                m_code = code;
                if (code == EXC_ADEL || code == EXC_ADES) m_bva = t.bva;
            end else if (er) begin
                m_exl = 1'b0;
            end else if (we) begin
                if (t.addr == CP0_STATUS) begin
                    m_im = t.wd[15:8]; m_exl = t.wd[1]; m_ie = t.wd[0];
                end else if (t.addr == CP0_CAUSE) begin
                    m_ipsw = t.wd[9:8];
                end else if (t.addr == CP0_EPC) begin
                    m_epc = t.wd;
                end
            end
            m_iphw = new_iphw;
        end
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin : monitor
        rsp_t a, e;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {Exc_Flush, Exc_Redirect, Exc_NPC, CP0Out};
            checks = checks + 1;
            if (a !== e)begin
                errors = errors + 1;
                $display("FAIL rsp cyc=%0d got flush=%b redir=%b npc=%h out=%h want flush=%b redir=%b npc=%h out=%h",
                         cyc, a.flush, a.redir, a.npc, a.out, e.flush, e.redir, e.npc, e.out);
            end
        end
    end

    initial begin
        txn_t t;
        logic [7:0] addrs [7];
        logic [4:0] codes [6];
        addrs[0] = CP0_BADVADDR; addrs[1] = CP0_COUNT; addrs[2] = CP0_COMPARE;
        addrs[3] = CP0_STATUS;   addrs[4] = CP0_CAUSE; addrs[5] = CP0_EPC; addrs[6] = 8'h08;
        codes[0] = EXC_ADEL; codes[1] = EXC_ADES; codes[2] = EXC_SYS;
        codes[3] = EXC_BP;   codes[4] = EXC_RI;   codes[5] = EXC_OV;
        rst = 1'b0; MEM_PC = '0; MEM_Exception = 0; MEM_ExcCode = '0; MEM_isBD = 0;
        badvaddr = '0; MEM_eret_flush = 0; MEM_CP0WrEn = 0; MEM_CP0Rd = 0;
        MEM_CP0Addr = '0; MEM_GPR_RT = '0; hw_int = '0;
        model_reset();

        // Reset holds outputs low even with an exception presented
        t = exc(32'h3010, EXC_OV, 1'b0, 32'h0); t.rst = 1'b0; t.rd = 1'b1; t.addr = CP0_STATUS;
        repeat (3) step(t);
        step(rd(CP0_STATUS), 1'b1, 32'h0040_0000);
        step(wr(CP0_COMPARE, 32'h8000_0000));
        step(idle()); step(idle());

        // Overflow, not in a delay slot
        step(exc(32'h3010, EXC_OV, 1'b0, 32'hDEAD_BEEF));
        step(rd(CP0_EPC), 1'b1, 32'h0000_3010);
        step(rd(CP0_CAUSE), 1'b1, 32'h0000_0030);
        step(rd(CP0_STATUS), 1'b1, 32'h0040_0002);
        step(rd(CP0_BADVADDR), 1'b1, 32'h0);

        // AdEL in a delay slot
        step(wr(CP0_STATUS, 32'h0));
        step(exc(32'h3024, EXC_ADEL, 1'b1, 32'h1001));
        step(rd(CP0_EPC), 1'b1, 32'h0000_3020);
        step(rd(CP0_CAUSE), 1'b1, 32'h8000_0010);
        step(rd(CP0_BADVADDR), 1'b1, 32'h0000_1001);

        // Nested exception while EXL=1
        step(exc(32'h4000, EXC_RI, 1'b0, 32'h0));
        step(rd(CP0_EPC), 1'b1, 32'h0000_3020);
        step(rd(CP0_CAUSE), 1'b1, 32'h8000_0028);

        // Interrupt: bubbles do not take it, a real instruction does
        step(wr(CP0_STATUS, 32'h0000_0401));
        t = idle(); t.hw = 6'b000001;
        step(t); step(t);
        t.pc = 32'h3100;
        step(t);
        step(rd(CP0_EPC), 1'b1, 32'h0000_3100);
        step(rd(CP0_CAUSE), 1'b1, 32'h0000_0000);

        // Timer match and TI clear
        step(wr(CP0_COMPARE, 32'd5));
        step(wr(CP0_COUNT, 32'd0));
        repeat (14) step(rd(CP0_CAUSE));
        step(rd(CP0_COUNT));
        step(wr(CP0_COMPARE, 32'h100));
        step(rd(CP0_CAUSE)); step(rd(CP0_CAUSE));

        // eret with a concurrent Status write that must be dropped
        step(wr(CP0_EPC, 32'h3200));
        t = wr(CP0_STATUS, 32'h0000_FF01); t.eret = 1'b1; t.pc = 32'h3300;
        step(t);
        step(rd(CP0_STATUS), 1'b1, 32'h0040_0401);

        // Reset during an exception abandons the update
        t = exc(32'h5000, EXC_ADES, 1'b1, 32'h77); t.rst = 1'b0;
        step(t);
        step(rd(CP0_STATUS), 1'b1, 32'h0040_0000);
        step(rd(CP0_EPC), 1'b1, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            t = idle();
            t.rst  = ($urandom_range(0, 99) != 0);
            t.pc   = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'h0000_FFFC);
            t.exc  = ($urandom_range(0, 7) == 0);
            t.code = codes[$urandom_range(0, 5)];
            t.bd   = 1'($urandom_range(0, 1));
            t.bva  = $urandom;
            t.eret = ($urandom_range(0, 9) == 0);
            t.we   = ($urandom_range(0, 2) == 0);
            t.rd   = 1'($urandom_range(0, 1));
            t.addr = ($urandom_range(0, 7) == 7) ? 8'($urandom) : addrs[$urandom_range(0, 6)];
            t.wd   = $urandom;
            t.hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            step(t);
        end

        step(idle());
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc.md
# cp0_exc

Coprocessor-0 exception commit unit: consumes the exception and CP0 fields latched into the MEM stage, and returns the flush and redirect for the pipeline registers and PC. It holds BadVAddr, Count, Compare, Status, Cause and EPC. It arbitrates interrupts, synchronous exceptions and `eret` at a single commit point, the MEM stage. It serves `mfc0` reads and `mtc0` writes.

## Interface
- `EXC_VEC`, default 32'hBFC0_0380: exception entry address.
- `STATUS_RST`, default 32'h0040_0000: Status reset value (BEV=1).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low (`rst`=0 resets on the clock edge).
- `MEM_PC` in 32: PC of the MEM-stage instruction; 0 marks a bubble.
- `MEM_Exception` in 1: the MEM-stage instruction carries an exception.
- `MEM_ExcCode` in 5: exception code.
- `MEM_isBD` in 1: the instruction sits in a branch delay slot.
- `badvaddr` in 32: faulting address.
- `MEM_eret_flush` in 1: the instruction is `eret`.
- `MEM_CP0WrEn` in 1: `mtc0` write enable.
- `MEM_CP0Rd` in 1: `mfc0` read enable.
- `MEM_CP0Addr` in 8: {rd[4:0], sel[2:0]}.
- `MEM_GPR_RT` in 32: `mtc0` write data.
- `hw_int` in 6: external interrupt lines, level-sensitive.
- `CP0Out` out 32: read data.
- `Exc_Flush` out 1: flush request to IF_ID, ID_EX and EX_MEM; also kills the MEM-stage RFWr/DMWr.
- `Exc_Redirect` out 1: PC must load `Exc_NPC`.
- `Exc_NPC` out 32: redirect target.

## Operation
- Register addresses:
  - BadVAddr 0x40.
  - Count 0x48.
  - Compare 0x58.
  - Status 0x60.
  - Cause 0x68.
  - EPC 0x70.
  - Any other address: reads 0, writes are ignored.
- Status fields:
  - Writable: IM[15:8], EXL[1], IE[0].
  - BEV[22] is read-only and reads 1.
  - All other bits read 0.
- Cause fields:
  - Writable: IP[9:8] (software interrupts) only.
  - BD[31] and TI[30] are read-only.
  - IP[15:10] = {TI | hw_int[5], hw_int[4:0]}, sampled each cycle.
  - ExcCode[6:2] is read-only.
- Timer:
  - Count increments on every second cycle, driven by an internal toggle.
  - TI sets when Count==Compare.
  - A write to Compare clears TI.
  - A write to Count loads the value and clears the toggle.
- Interrupt pending: `int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)`. An interrupt is taken only when `MEM_PC != 0`.
- Priority per cycle, highest first:
  1. Interrupt: treated as ExcCode 0.
  2. `MEM_Exception`.
  3. `MEM_eret_flush`.
  4. `mtc0`.
- Exception entry (case 1 or 2):
  - If EXL was 0: EPC ← `MEM_isBD` ? `MEM_PC`−4 : `MEM_PC`; BD ← `MEM_isBD`.
  - EXL ← 1.
  - ExcCode ← code.
  - BadVAddr ← `badvaddr` only for AdEL(4) and AdES(5).
  - `Exc_NPC` = `EXC_VEC`.
- `eret` (case 3): EXL ← 0; `Exc_NPC` = EPC, using the registered value, so an `mtc0 EPC` in the preceding instruction is visible.
- `mtc0` is dropped whenever case 1, 2 or 3 fires in the same cycle.
- `CP0Out` is combinational from `MEM_CP0Addr` when `MEM_CP0Rd`=1, else 0. It shows pre-update values.

## Timing
- `Exc_Flush`, `Exc_Redirect` and `Exc_NPC` are combinational in the commit cycle. Pipeline registers and PC act on the following edge, so the next cycle's MEM holds a bubble.
- CP0 register updates land on the commit-cycle edge, so they are visible one cycle later.
- Reset values:
  - Status = `STATUS_RST`.
  - Cause, EPC, BadVAddr, Count, Compare and the toggle = 0.
  - Outputs are 0 while `rst`=0 (redirect and flush deasserted).
- Reset asserted mid-exception: the update is abandoned and all registers take their reset values.
- Count wraps from 0xFFFF_FFFF to 0 silently.
- If Count==Compare holds at the same edge as a Compare write, the write wins and TI=0.

## Structure
- MacroDef.v gains:
  - CP0 address constants (`CP0_BADVADDR` … `CP0_EPC`).
  - Exception codes `Int`, `Sys`, `Bp`, `RI`, alongside the existing `Ov`, `AdEL`, `AdES`.
  - Field bit positions.
- Sub-module `cp0_timer`: Count, Compare, the toggle and TI. Ports: write strobes, write data, `CountOut`, `CompareOut`, `TI`.

## Test plan
- Overflow with `MEM_PC`=0x3010, ExcCode 12, isBD=0 → same cycle: Flush=1, NPC=0xBFC00380. Next cycle: EPC=0x3010, Cause[6:2]=12, Status.EXL=1, BadVAddr unchanged.
- AdEL in a delay slot, PC=0x3024, badvaddr=0x1001 → EPC=0x3020, Cause.BD=1, BadVAddr=0x1001.
- Exception while EXL=1, PC=0x4000 → EPC keeps its prior value, ExcCode updates, flush asserted.
- `mtc0` Status=0x0000_0401, then `hw_int[0]`=1 with `MEM_PC`=0x3100 → interrupt taken: ExcCode 0, EPC=0x3100. The same stimulus with `MEM_PC`=0 (bubble) → no flush.
- Write Compare=5 and Count=0 → TI=1 about 10 cycles after the Count write. Cause reads bit30 set. Rewriting Compare clears TI.
- `eret` with EPC=0x3200 and EXL=1 → NPC=0x3200 and Flush=1; EXL=0 next cycle. An `eret` concurrent with `mtc0` Status → Status write dropped.
